// File: rtl/slot_pkg.sv
// Shared constants and state type for the coin payout path.
package slot_pkg;

  localparam int CREDIT_W_DEF    = 5;
  localparam int ACK_TIMEOUT_DEF = 50_000_000;
  localparam int GAP_CYCLES_DEF  = 12_500_000;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    GAP,
    DONE,
    JAM
  } state_e;

  // One shared counter times both DRIVE and GAP, so size it for the longer of the two.
  function automatic int timer_width(input int ack_cycles, input int gap_cycles);
    int longest;
    longest = (ack_cycles > gap_cycles) ? ack_cycles : gap_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/payout_dispenser_if.sv
// Signal bundle between the cash-out/credit logic, the hopper pins and the payout controller.
interface payout_dispenser_if #(
  parameter int CREDIT_W = 5
);
  logic                cashout;
  logic [CREDIT_W-1:0] credit_in;
  logic                coin_sensed;
  logic                coin_out;
  logic                busy;
  logic [CREDIT_W-1:0] remaining;
  logic [CREDIT_W-1:0] paid_count;
  logic                done;
  logic                jam;

  modport master (
    output cashout, credit_in, coin_sensed,
    input  coin_out, busy, remaining, paid_count, done, jam
  );

  modport slave (
    input  cashout, credit_in, coin_sensed,
    output coin_out, busy, remaining, paid_count, done, jam
  );
endinterface

// File: rtl/sync_edge.sv
// Optional 2-flop synchroniser followed by a rising-edge detector (one-cycle pulse).
module sync_edge #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sync_w;
  logic prev_q;

  if (SYNC_EN) begin : g_sync
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= sig_i;
        sync_q <= meta_q;
      end
    end

    assign sync_w = sync_q;
  end else begin : g_bypass
    assign sync_w = sig_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_w;
    end
  end

  assign rise_o = sync_w & ~prev_q;

endmodule

// File: rtl/payout_dispenser.sv
// Pays out a credit snapshot one hopper coin at a time, each confirmed by the coin sensor.
// Build option JAM_RETRY_EN gives each coin one retry (via GAP) before declaring a jam.
//   state | meaning
//   IDLE  | waiting for a cash-out rise
//   DRIVE | coin_out high, waiting for the sensor to confirm
//   GAP   | hopper recovery between coins
//   DONE  | one-cycle completion pulse
//   JAM   | sensor never confirmed; waits for a new cash-out rise
module payout_dispenser
  import slot_pkg::*;
#(
  parameter int CREDIT_W    = CREDIT_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input logic               CLOCK_50,
  input logic               reset,
  payout_dispenser_if.slave bus
);

  localparam int TIMER_W = timer_width(ACK_TIMEOUT, GAP_CYCLES);
  localparam logic [TIMER_W-1:0] ACK_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

  logic coin_rise;
  logic cash_rise;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic [CREDIT_W-1:0] paid_q, paid_d;
  logic                jam_q, jam_d;
  logic                done_q, done_d;
  logic                coin_q, busy_q;
`ifdef JAM_RETRY_EN
  logic                retry_q, retry_d;
`endif

  sync_edge #(.SYNC_EN(1'b1)) u_coin_edge (
    .clk    (CLOCK_50),
    .rst    (reset),
    .sig_i  (bus.coin_sensed),
    .rise_o (coin_rise)
  );

  // cashout comes from on-chip logic already in this clock domain
  sync_edge #(.SYNC_EN(1'b0)) u_cash_edge (
    .clk    (CLOCK_50),
    .rst    (reset),
    .sig_i  (bus.cashout),
    .rise_o (cash_rise)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    paid_d  = paid_q;
    jam_d   = jam_q;
    done_d  = 1'b0;
`ifdef JAM_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      IDLE, JAM: begin
        if (cash_rise) begin
          jam_d   = 1'b0;
          rem_d   = bus.credit_in;
          paid_d  = '0;
          timer_d = '0;
`ifdef JAM_RETRY_EN
          retry_d = 1'b0;
`endif
          if (bus.credit_in != '0) begin
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DRIVE: begin
        // a confirmation landing on the timeout cycle still counts as paid
        if (coin_rise) begin
          rem_d   = rem_q - 1'b1;
          paid_d  = paid_q + 1'b1;
          timer_d = '0;
`ifdef JAM_RETRY_EN
          retry_d = 1'b0;
`endif
          if (rem_q == CREDIT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else if (timer_q == ACK_LAST) begin
          timer_d = '0;
`ifdef JAM_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = GAP;
          end else begin
            state_d = JAM;
            jam_d   = 1'b1;
          end
`else
          state_d = JAM;
          jam_d   = 1'b1;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = DRIVE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      paid_q  <= '0;
      jam_q   <= 1'b0;
      done_q  <= 1'b0;
      coin_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      paid_q  <= paid_d;
      jam_q   <= jam_d;
      done_q  <= done_d;
      coin_q  <= (state_d == DRIVE);
      busy_q  <= (state_d == DRIVE) || (state_d == GAP);
    end
  end

`ifdef JAM_RETRY_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign bus.coin_out   = coin_q;
  assign bus.busy       = busy_q;
  assign bus.remaining  = rem_q;
  assign bus.paid_count = paid_q;
  assign bus.done       = done_q;
  assign bus.jam        = jam_q;

endmodule

// File: tb/tb_payout_dispenser.sv
// Bench for payout_dispenser: directed scenarios plus random traffic against a cycle-level payout model.
module tb_payout_dispenser;

  localparam int CW   = 5;
  localparam int ACK  = 8;
  localparam int GAPC = 4;
  localparam int M_IDLE = 0, M_DRIVE = 1, M_GAP = 2, M_DONE = 3, M_JAM = 4;
`ifdef JAM_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  payout_dispenser_if #(.CREDIT_W(CW)) bus ();

  payout_dispenser #(
    .CREDIT_W    (CW),
    .ACK_TIMEOUT (ACK),
    .GAP_CYCLES  (GAPC)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- payout model: what the hopper controller must do each clock
  int               mode    = M_IDLE;
  int               elapsed = 0;
  bit               retried = 1'b0;
  logic             h1 = 1'b0, h2 = 1'b0, h3 = 1'b0, c_prev = 1'b0;
  logic             sensed, rise;
  logic             m_coin = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_jam = 1'b0;
  logic [CW-1:0]    m_rem = '0, m_paid = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = M_IDLE; elapsed = 0; retried = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; c_prev = 1'b0;
      m_coin = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_jam = 1'b0;
      m_rem = '0; m_paid = '0;
    end else begin
      // the sensor pin is seen as a confirmation two clocks after it is first sampled high
      sensed = h2 && !h3;
      rise   = bus.cashout && !c_prev;
      h3 = h2; h2 = h1; h1 = bus.coin_sensed;
      c_prev = bus.cashout;
      m_done = 1'b0;
      if (mode == M_IDLE || mode == M_JAM) begin
        if (rise) begin
          m_jam = 1'b0; m_rem = bus.credit_in; m_paid = '0; retried = 1'b0; elapsed = 0;
          if (bus.credit_in != 0) mode = M_DRIVE;
          else begin mode = M_IDLE; m_done = 1'b1; end
        end
      end else if (mode == M_DRIVE) begin
        elapsed++;
        if (sensed) begin
          m_rem = m_rem - 1'b1; m_paid = m_paid + 1'b1; retried = 1'b0; elapsed = 0;
          if (m_rem == 0) begin mode = M_DONE; m_done = 1'b1; end
          else mode = M_GAP;
        end else if (elapsed == ACK) begin
          elapsed = 0;
          if (RETRY && !retried) begin retried = 1'b1; mode = M_GAP; end
          else begin mode = M_JAM; m_jam = 1'b1; end
        end
      end else if (mode == M_GAP) begin
        elapsed++;
        if (elapsed == GAPC) begin elapsed = 0; mode = M_DRIVE; end
      end else begin
        mode = M_IDLE;
      end
      m_coin = (mode == M_DRIVE);
      m_busy = (mode == M_DRIVE) || (mode == M_GAP);
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("coin_out",   32'(bus.coin_out),   32'(m_coin));
      chk("busy",       32'(bus.busy),       32'(m_busy));
      chk("remaining",  32'(bus.remaining),  32'(m_rem));
      chk("paid_count", 32'(bus.paid_count), 32'(m_paid));
      chk("done",       32'(bus.done),       32'(m_done));
      chk("jam",        32'(bus.jam),        32'(m_jam));
    end
  end

  // ---------------- observation counters for the hand-computed checks
  int   coin_rise_cnt = 0, coin_high_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int   low_run = 0, last_gap = 0;
  logic done_busy_last = 1'b0;
  logic mon_co_prev = 1'b0, mon_busy_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.coin_out === 1'b1) begin
      coin_high_cnt++;
      if (!mon_co_prev) begin
        coin_rise_cnt++;
        if (mon_busy_prev) last_gap = low_run;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_busy_last = bus.busy;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    mon_co_prev   = bus.coin_out;
    mon_busy_prev = bus.busy;
  end

  // ---------------- hopper: answers coin_out according to hop_mode
  int hop_mode = 0;   // 0 never senses, 1 senses 2 cycles after coin_out rise, 2 random
  bit stray_en = 1'b0;

  initial begin
    int   cnt;
    int   pulse_left;
    int   stray_left;
    logic co_prev;
    cnt = -1; pulse_left = 0; stray_left = 0; co_prev = 1'b0;
    bus.coin_sensed = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.coin_out === 1'b1 && !co_prev) begin
        if (hop_mode == 1) cnt = 2;
        else if (hop_mode == 2) cnt = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 9));
        else cnt = -1;
      end
      if (bus.coin_out === 1'b0 && co_prev && stray_en) stray_left = 1;
      if (hop_mode == 2 && $urandom_range(0, 60) == 0) stray_left = 1;
      if (cnt == 0) pulse_left = 2;
      if (cnt >= 0) cnt--;
      bus.coin_sensed = (pulse_left > 0) || (stray_left > 0);
      if (pulse_left > 0) pulse_left--;
      if (stray_left > 0) stray_left--;
      co_prev = (bus.coin_out === 1'b1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base_rise, base_high, base_done, base_busy, n;
    bus.cashout = 1'b0;
    bus.credit_in = '0;
    #1 rst = 1'b1;
    cyc(3);
    run_chk = 1'b1;
    #2 rst = 1'b0;
    cyc(2);

    // normal payout of 3 coins
    hop_mode = 1;
    base_rise = coin_rise_cnt; base_done = done_cnt;
    bus.credit_in = 5'd3; bus.cashout = 1'b1;
    cyc(60);
    chk("s2_coins",     32'(coin_rise_cnt - base_rise), 32'd3);
    chk("s2_paid",      32'(bus.paid_count), 32'd3);
    chk("s2_remaining", 32'(bus.remaining),  32'd0);
    chk("s2_done_cnt",  32'(done_cnt - base_done), 32'd1);
    chk("s2_busy_at_done", 32'(done_busy_last), 32'd0);
    chk("s2_gap_len",   32'(last_gap), 32'd4);
    bus.cashout = 1'b0;
    cyc(3);

    // zero credit
    base_rise = coin_rise_cnt; base_done = done_cnt; base_busy = busy_cnt;
    bus.credit_in = 5'd0; bus.cashout = 1'b1;
    cyc(10);
    chk("s3_done_cnt", 32'(done_cnt - base_done), 32'd1);
    chk("s3_coins",    32'(coin_rise_cnt - base_rise), 32'd0);
    chk("s3_busy_cyc", 32'(busy_cnt - base_busy), 32'd0);
    bus.cashout = 1'b0;
    cyc(3);

    // hopper never senses -> jam, then recovery
    hop_mode = 0;
    base_high = coin_high_cnt;
    bus.credit_in = 5'd2; bus.cashout = 1'b1;
    cyc(40);
    chk("s4_drive_cycles", 32'(coin_high_cnt - base_high), RETRY ? 32'd16 : 32'd8);
    chk("s4_jam",       32'(bus.jam), 32'd1);
    chk("s4_remaining", 32'(bus.remaining), 32'd2);
    chk("s4_paid",      32'(bus.paid_count), 32'd0);
    chk("s4_busy",      32'(bus.busy), 32'd0);
    if (RETRY) chk("s4_retry_gap", 32'(last_gap), 32'd4);
    bus.cashout = 1'b0;
    cyc(2);
    hop_mode = 1;
    bus.credit_in = 5'd1; bus.cashout = 1'b1;
    cyc(2);
    chk("s4_jam_cleared", 32'(bus.jam), 32'd0);
    chk("s4_restart_busy", 32'(bus.busy), 32'd1);
    cyc(20);
    chk("s4_restart_paid", 32'(bus.paid_count), 32'd1);
    bus.cashout = 1'b0;
    cyc(2);

    // held cashout, extra rise while busy, stray sensor pulses in GAP
    stray_en = 1'b1;
    base_rise = coin_rise_cnt; base_done = done_cnt;
    bus.credit_in = 5'd4; bus.cashout = 1'b1;
    cyc(10);
    bus.cashout = 1'b0;
    cyc(1);
    bus.cashout = 1'b1;
    cyc(80);
    chk("s5_coins",     32'(coin_rise_cnt - base_rise), 32'd4);
    chk("s5_paid",      32'(bus.paid_count), 32'd4);
    chk("s5_remaining", 32'(bus.remaining), 32'd0);
    chk("s5_done_cnt",  32'(done_cnt - base_done), 32'd1);
    cyc(20);
    chk("s5_no_restart", 32'(coin_rise_cnt - base_rise), 32'd4);
    stray_en = 1'b0;
    bus.cashout = 1'b0;
    cyc(2);

    // reset in the middle of the third coin
    base_rise = coin_rise_cnt;
    bus.credit_in = 5'd5; bus.cashout = 1'b1;
    n = 0;
    while (!(bus.paid_count == 5'd2 && bus.coin_out === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("s1_reached_third_coin", 32'(n < 300), 32'd1);
    #2 rst = 1'b1; bus.cashout = 1'b0;
    #1;
    chk("s1_coin_out_async", 32'(bus.coin_out), 32'd0);
    chk("s1_busy",       32'(bus.busy), 32'd0);
    chk("s1_remaining",  32'(bus.remaining), 32'd0);
    chk("s1_paid",       32'(bus.paid_count), 32'd0);
    cyc(2);
    #2 rst = 1'b0;
    cyc(30);
    chk("s1_nothing_owed", 32'(coin_rise_cnt - base_rise), 32'd3);

    // random traffic
    hop_mode = 2;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        #2 rst = 1'b1; bus.cashout = 1'b0;
        cyc(1);
        #2 rst = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) bus.credit_in = 5'($urandom_range(0, 31));
        else bus.credit_in = 5'($urandom_range(0, 6));
        bus.cashout = 1'($urandom_range(0, 1));
      end
      cyc($urandom_range(1, 25));
    end
    bus.cashout = 1'b0;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
